i2s_tdm_rx: RTL

I2S_TDM_RX -- requirements
Module: i2s_tdm_rx

---
 rtl/i2s_tdm_rx_if.sv | 13 +
 rtl/i2s_tdm_rx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/i2s_tdm_rx_if.sv
// Output handshake bundle of the I2S/TDM receiver: sample word, channel tag, valid/ready.
interface i2s_tdm_rx_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_W       = 1
);
  logic [DATA_WIDTH-1:0] o_data;
  logic [CH_W-1:0]       o_ch;
  logic                  o_valid;
  logic                  i_ready;

  modport master (output o_data, output o_ch, output o_valid, input i_ready);
  modport slave  (input o_data, input o_ch, input o_valid, output i_ready);
endinterface

// File: rtl/i2s_tdm_rx.sv
// I2S / TDM serial receiver: a word enters the FIFO on the edge sampling its LSB, o_valid follows one cycle later.
// Backpressure: FIFO holds words while i_ready is low; a push into a full FIFO without a pop is dropped and flags o_overflow.
module i2s_tdm_rx #(
  parameter int  DATA_WIDTH = 16,
  parameter int  SLOT_WIDTH = 32,
  parameter int  NUM_CH     = 2,
  parameter int  FIFO_DEPTH = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic         i_sck,
  input  logic         i_sys_rst,
  input  logic         i_ws,
  input  logic         i_sd,
  input  logic         i_mode,
  input  logic         i_ovf_clr,
  i2s_tdm_rx_if.master out_if,
  output logic         o_overflow,
  output logic         o_frame_err,
  output logic         o_locked
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(SLOT_WIDTH + 1);
  localparam logic [BCW-1:0]  LAST_DBIT = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0]  LAST_SBIT = BCW'(SLOT_WIDTH - 1);
  localparam logic [BCW-1:0]  DW_CNT    = BCW'(DATA_WIDTH);
  localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_CH - 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t                state;
  logic                  ws_d;
  logic                  mode_d;
  logic [BCW-1:0]        bit_cnt;
  logic [CH_W-1:0]       slot_cnt;
  logic [DATA_WIDTH-1:0] shreg;

  logic                  ws_rise, ws_fall, mode_chg, in_word, tdm_last, push_vld;
  logic [DATA_WIDTH-1:0] word_nxt;

  assign ws_rise  = ~ws_d & i_ws;
  assign ws_fall  = ws_d & ~i_ws;
  assign mode_chg = i_mode != mode_d;
  assign in_word  = bit_cnt < DW_CNT;
  assign tdm_last = (bit_cnt == LAST_SBIT) && (slot_cnt == LAST_SLOT);
  assign word_nxt = {shreg[DATA_WIDTH-2:0], i_sd};
  // The current bit is folded in before any ws boundary is acted on, so an LSB sampled on a boundary edge still completes its word.
  assign push_vld = (state == RECV) && !mode_chg && (bit_cnt == LAST_DBIT);

  assign o_locked = (state == RECV);

  always_ff @(posedge i_sck or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state       <= HUNT;
      ws_d        <= 1'b0;
      mode_d      <= 1'b0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      shreg       <= '0;
      o_frame_err <= 1'b0;
    end else begin
      ws_d        <= i_ws;
      mode_d      <= i_mode;
      o_frame_err <= 1'b0;
      if (in_word) shreg <= word_nxt;
      if (mode_chg) begin
        state <= HUNT;
      end else begin
        case (state)
          HUNT: begin
            if ((!i_mode && ws_fall) || (i_mode && ws_rise)) begin
              state    <= RECV;
              bit_cnt  <= '0;
              slot_cnt <= '0;
            end
          end
          RECV: begin
            if (!i_mode) begin
              if (ws_rise || ws_fall) begin
                if (bit_cnt < LAST_DBIT) o_frame_err <= 1'b1;
                bit_cnt  <= '0;
                slot_cnt <= CH_W'(i_ws);
              end else if (in_word) begin
                bit_cnt <= bit_cnt + BCW'(1);
              end
            end else begin
              if (ws_rise) begin
                if (!tdm_last) o_frame_err <= 1'b1;
                bit_cnt  <= '0;
                slot_cnt <= '0;
              end else if (tdm_last) begin
                o_frame_err <= 1'b1;
                state       <= HUNT;
              end else if (bit_cnt == LAST_SBIT) begin
                bit_cnt  <= '0;
                slot_cnt <= slot_cnt + CH_W'(1);
              end else begin
                bit_cnt <= bit_cnt + BCW'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Output FIFO; the extra pointer bit separates full from empty.
  logic [DATA_WIDTH+CH_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]                wr_ptr, rd_ptr;
  logic                       empty, full, pop, wr_en, drop;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && out_if.i_ready;
  assign wr_en = push_vld && (!full || pop);
  assign drop  = push_vld && full && !pop;

  always_ff @(posedge i_sck) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {slot_cnt, word_nxt};
  end

  always_ff @(posedge i_sck or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)           o_overflow <= 1'b1;
      else if (i_ovf_clr) o_overflow <= 1'b0;
    end
  end

  assign out_if.o_valid             = !empty;
  assign {out_if.o_ch, out_if.o_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
